bypass_ctrl: RTL

Forwarding and load-use hazard control for the 5-stage pipeline. It sits in ID and tracks the destination tags of the instructions in EX and MEM. It produces the six registered bypass selects that steer the EX-stage operand muxes (EX/MEM ALU result or MEM/WB value versus ID/EX operands). It also raises a one-cycle stall on a load-use dependency and counts stall cycles.

---
 rtl/bypass_pkg.sv | 53 +++++
 rtl/bypass_tag_reg.sv | 32 +++
 rtl/bypass_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/bypass_pkg.sv
// ============================================================================
// bypass_pkg : shared types and helpers for forwarding/load-use control
// Revision   : 1.0
// ============================================================================
`default_nettype none

package bypass_pkg;

  localparam int DEF_REG_W = 5;
  localparam int DEF_CNT_W = 16;

  typedef struct packed {
    logic                 valid;
    logic [DEF_REG_W-1:0] dest;
    logic                 regwrite;
    logic                 memread;
  } hazard_tag_t;

  localparam hazard_tag_t BUBBLE_TAG = '{valid: 1'b0, dest: '0, regwrite: 1'b0, memread: 1'b0};

  typedef struct packed {
    logic from_mem;
    logic alu_in_wb;
    logic lw_in_wb;
  } operand_sel_t;

  localparam operand_sel_t NO_BYPASS = '{from_mem: 1'b0, alu_in_wb: 1'b0, lw_in_wb: 1'b0};

  // r0 is hardwired, so a producer targeting it never counts as a match
  function automatic logic tag_match(input hazard_tag_t          tag,
                                     input logic [DEF_REG_W-1:0] src,
                                     input logic                 use_src);
    return tag.valid & tag.regwrite & (tag.dest != '0) & (tag.dest == src) & use_src;
  endfunction

  function automatic operand_sel_t operand_sel(input hazard_tag_t          ex_tag,
                                               input hazard_tag_t          mem_tag,
                                               input logic [DEF_REG_W-1:0] src,
                                               input logic                 use_src);
    operand_sel_t sel;
    logic         m_ex;
    logic         m_mem;
    m_ex          = tag_match(ex_tag, src, use_src);
    m_mem         = tag_match(mem_tag, src, use_src);
    sel.from_mem  = m_ex & ~ex_tag.memread;
    sel.alu_in_wb = ~m_ex & m_mem & ~mem_tag.memread;
    sel.lw_in_wb  = ~m_ex & m_mem & mem_tag.memread;
    return sel;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bypass_tag_reg.sv
// ============================================================================
// bypass_tag_reg : one hazard-tracker stage with freeze and bubble insert
// Revision       : 1.0
// ============================================================================
`default_nettype none

module bypass_tag_reg
  import bypass_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_hold,
  input  logic        i_bubble,
  input  hazard_tag_t i_tag,
  output hazard_tag_t o_tag
);

  hazard_tag_t r_tag;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag <= BUBBLE_TAG;
    end else if (!i_hold) begin
      r_tag <= i_bubble ? BUBBLE_TAG : i_tag;
    end
  end

  assign o_tag = r_tag;

endmodule

`default_nettype wire

// File: rtl/bypass_ctrl.sv
// ============================================================================
// bypass_ctrl : ID-stage forwarding select and load-use stall generation
// Revision    : 1.0
// ============================================================================
`default_nettype none

module bypass_ctrl
  import bypass_pkg::*;
#(
  parameter int REG_W = DEF_REG_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hold,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_regwrite,
  input  logic             id_memread,
  output logic             stall,
  output logic             bypassAfromMEM,
  output logic             bypassAfromALUinWB,
  output logic             bypassAfromLWinWB,
  output logic             bypassBfromMEM,
  output logic             bypassBfromALUinWB,
  output logic             bypassBfromLWinWB,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  hazard_tag_t      w_ex_tag;
  hazard_tag_t      w_mem_tag;
  hazard_tag_t      w_id_tag;
  logic             w_match_ex_rs;
  logic             w_match_ex_rt;
  logic             w_stall;
  logic             w_bubble;
  operand_sel_t     w_sel_a;
  operand_sel_t     w_sel_b;
  operand_sel_t     r_sel_a;
  operand_sel_t     r_sel_b;
  logic [CNT_W-1:0] r_stall_count;

  assign w_id_tag = '{valid: id_valid, dest: id_dest, regwrite: id_regwrite, memread: id_memread};

  assign w_match_ex_rs = tag_match(w_ex_tag, id_rs, id_use_rs);
  assign w_match_ex_rt = tag_match(w_ex_tag, id_rt, id_use_rt);

  // Only distance-1 loads stall; a load already in MEM is covered by LWinWB
  assign w_stall  = ~hold & ~flush & id_valid & w_ex_tag.memread & (w_match_ex_rs | w_match_ex_rt);
  assign w_bubble = w_stall | flush | ~id_valid;

  assign w_sel_a = operand_sel(w_ex_tag, w_mem_tag, id_rs, id_use_rs);
  assign w_sel_b = operand_sel(w_ex_tag, w_mem_tag, id_rt, id_use_rt);

  bypass_tag_reg u_ex_tag (
    .clk      (clk),
    .rst      (reset),
    .i_hold   (hold),
    .i_bubble (w_bubble),
    .i_tag    (w_id_tag),
    .o_tag    (w_ex_tag)
  );

  bypass_tag_reg u_mem_tag (
    .clk      (clk),
    .rst      (reset),
    .i_hold   (hold),
    .i_bubble (1'b0),
    .i_tag    (w_ex_tag),
    .o_tag    (w_mem_tag)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sel_a <= NO_BYPASS;
      r_sel_b <= NO_BYPASS;
    end else if (!hold) begin
      r_sel_a <= w_bubble ? NO_BYPASS : w_sel_a;
      r_sel_b <= w_bubble ? NO_BYPASS : w_sel_b;
    end
  end

  // w_stall is already gated by hold, so a frozen pipeline never counts
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_count <= '0;
    end else if (w_stall && (r_stall_count != c_CNT_MAX)) begin
      r_stall_count <= r_stall_count + c_CNT_ONE;
    end
  end

  assign stall              = w_stall;
  assign bypassAfromMEM     = r_sel_a.from_mem;
  assign bypassAfromALUinWB = r_sel_a.alu_in_wb;
  assign bypassAfromLWinWB  = r_sel_a.lw_in_wb;
  assign bypassBfromMEM     = r_sel_b.from_mem;
  assign bypassBfromALUinWB = r_sel_b.alu_in_wb;
  assign bypassBfromLWinWB  = r_sel_b.lw_in_wb;
  assign stall_count        = r_stall_count;

endmodule

`default_nettype wire
